// File: rtl/cnn_mem_pkg.sv
// Shared definitions for the CNN memory-side blocks: image geometry,
// the window-reader state encoding and the buffered tap entry.
package cnn_mem_pkg;

    localparam int DATA_W  = 8;
    localparam int KERN_AW = 4;
    localparam int PIX_AW  = 6;
    localparam int IMG_W   = 8;
    localparam int WIN     = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [3:0]        tap;
        logic              last;
        logic              pad;
    } tap_entry_t;

    // Row offset of a raster-order tap inside the window (tap / WIN).
    function automatic logic [1:0] tap_row_off(input logic [3:0] tap);
        if (tap < 4'(WIN))   return 2'd0;
        if (tap < 4'(2*WIN)) return 2'd1;
        return 2'd2;
    endfunction

    // Column offset of a raster-order tap inside the window (tap % WIN).
    function automatic logic [1:0] tap_col_off(input logic [3:0] tap);
        logic [3:0] r;
        r = 4'(tap_row_off(tap));
        return 2'(tap - (r + r + r));
    endfunction

endpackage

// File: rtl/win_skid_fifo.sv
// Two-entry FIFO of tap entries that absorbs MAC backpressure between
// the SRAM capture stage and the window output handshake.
module win_skid_fifo
    import cnn_mem_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  tap_entry_t wdata_i,
    output tap_entry_t rdata_o,
    output logic [1:0] count_o,
    output logic       empty_o,
    output logic       full_o
);

    tap_entry_t mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        // NOTE: every output of this block is given a default first, so no path leaves it unassigned and no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
        if (do_push) wr_ptr_d = !wr_ptr_q;
        if (do_pop)  rd_ptr_d = !rd_ptr_q;
    end

    // Pointer and occupancy registers, cleared by reset.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage written on push.
    always_ff @(posedge Clk) begin
        // NOTE: storage is deliberately not reset; consumers gate the head entry with empty_o instead.
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sram_window_reader.sv
// Reads one WIN x WIN window of pixels from an image slot of the syncRAM
// and streams the taps in raster order over valid/ready, with a two-entry
// buffer and credit-based read issue.
// Optional feature: define SRAM_WINDOW_PAD_EN to zero-pad taps that fall
// outside the image instead of rejecting out-of-range corners.
module sram_window_reader
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W  = cnn_mem_pkg::DATA_W,
    parameter int KERN_AW = cnn_mem_pkg::KERN_AW,
    parameter int PIX_AW  = cnn_mem_pkg::PIX_AW,
    parameter int IMG_W   = cnn_mem_pkg::IMG_W,
    parameter int WIN     = cnn_mem_pkg::WIN
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               start,
    input  logic [KERN_AW-1:0] startKern,
    input  logic [2:0]         startRow,
    input  logic [2:0]         startCol,
    output logic               busy,
    output logic               err,
    output logic [KERN_AW-1:0] kernAddr,
    output logic [PIX_AW-1:0]  pixAddr,
    output logic               CS,
    output logic               RD,
    output logic               WE,
    input  logic [DATA_W-1:0]  dataIn,
    output logic [DATA_W-1:0]  winData,
    output logic [3:0]         winTap,
    output logic               winValid,
    input  logic               winReady,
    output logic               winLast
);

    localparam logic [3:0] LAST_TAP = 4'(WIN*WIN - 1);

    state_e             state_q, state_d;
    logic [KERN_AW-1:0] kern_q, kern_d;
    logic [2:0]         row_q, row_d;
    logic [2:0]         col_q, col_d;
    logic [3:0]         tap_q, tap_d;
    logic               infl_q, infl_d;
    logic [3:0]         infl_tap_q, infl_tap_d;
    logic               infl_pad_q, infl_pad_d;
    logic               err_q, err_d;

    logic [3:0] row_sum, col_sum;
    logic       pad_tap, start_bad, issue, pop;
    logic [2:0] occupancy;
    tap_entry_t push_entry, head;
    logic [1:0] fifo_count;
    logic       fifo_empty, fifo_full;

    // Address generation for the tap currently being issued.
    assign row_sum = 4'(row_q) + 4'(tap_row_off(tap_q));
    assign col_sum = 4'(col_q) + 4'(tap_col_off(tap_q));
    assign pixAddr = PIX_AW'(8'(row_sum) * 8'(IMG_W) + 8'(col_sum));
    assign kernAddr = kern_q;

`ifdef SRAM_WINDOW_PAD_EN
    assign pad_tap   = (row_sum >= 4'(IMG_W)) || (col_sum >= 4'(IMG_W));
    assign start_bad = 1'b0;
`else
    localparam logic [2:0] MAX_CORNER = 3'(IMG_W - WIN);
    assign pad_tap   = 1'b0;
    assign start_bad = (startRow > MAX_CORNER) || (startCol > MAX_CORNER);
`endif

    // A pop in this cycle returns its credit immediately, so the steady
    // state with winReady high sustains one tap per cycle.
    assign pop       = winValid && winReady;
    assign occupancy = 3'(fifo_count) + 3'(infl_q) - 3'(pop);
    assign issue     = (state_q == ISSUE) && (occupancy < 3'd2);

    assign CS   = issue && !pad_tap;
    assign RD   = issue && !pad_tap;
    assign WE   = 1'b0;
    assign busy = (state_q != IDLE);
    assign err  = err_q;

    // Output view of the buffer head; zero whenever the buffer is empty.
    assign winValid = !fifo_empty;
    assign winData  = (winValid && !head.pad) ? head.data : '0;
    assign winTap   = winValid ? head.tap : 4'd0;
    assign winLast  = winValid && head.last;

    assign push_entry = '{data: dataIn, tap: infl_tap_q,
                          last: (infl_tap_q == LAST_TAP), pad: infl_pad_q};

    win_skid_fifo u_fifo (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .push_i  (infl_q),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Sequencer next-state: accept/reject start, issue taps, drain.
    always_comb begin
        state_d    = state_q;
        kern_d     = kern_q;
        row_d      = row_q;
        col_d      = col_q;
        tap_d      = tap_q;
        err_d      = 1'b0;
        infl_d     = issue;
        infl_tap_d = tap_q;
        infl_pad_d = pad_tap;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_bad) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        kern_d  = startKern;
                        row_d   = startRow;
                        col_d   = startCol;
                        tap_d   = 4'd0;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    tap_d = tap_q + 4'd1;
                    if (tap_q == LAST_TAP) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && winLast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q    <= IDLE;
            kern_q     <= '0;
            row_q      <= 3'd0;
            col_q      <= 3'd0;
            tap_q      <= 4'd0;
            infl_q     <= 1'b0;
            infl_tap_q <= 4'd0;
            infl_pad_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            kern_q     <= kern_d;
            row_q      <= row_d;
            col_q      <= col_d;
            tap_q      <= tap_d;
            infl_q     <= infl_d;
            infl_tap_q <= infl_tap_d;
            infl_pad_q <= infl_pad_d;
            err_q      <= err_d;
        end
    end

    // The credit rule must keep the buffer from ever overflowing.
    always_ff @(posedge Clk) begin
        if (Rst_n) assert (!(infl_q && fifo_full && !pop));
    end

endmodule

// File: tb/tb_sram_window_reader.sv
// Directed self-checking bench for sram_window_reader with a behavioural
// synchronous SRAM. Slot k, pixel p holds {k[1:0], p}, so slot 0 holds p.
module tb_sram_window_reader;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       start;
    logic [3:0] startKern;
    logic [2:0] startRow, startCol;
    logic       busy, err, CS, RD, WE;
    logic [3:0] kernAddr;
    logic [5:0] pixAddr;
    logic [7:0] dataIn;
    logic [7:0] winData;
    logic [3:0] winTap;
    logic       winValid, winReady, winLast;

    logic [7:0] mem [0:1023];
    logic [7:0] sram_q = 8'd0;

    int n_cmp  = 0;
    int n_fail = 0;

    int ev_r2c3 [9] = '{19, 20, 21, 27, 28, 29, 35, 36, 37};
    int ev_kA   [9] = '{147, 148, 149, 155, 156, 157, 163, 164, 165};
    int ev_pad  [9] = '{54, 55, 0, 62, 63, 0, 0, 0, 0};
    int ea_pad  [9] = '{54, 55, 62, 63, 0, 0, 0, 0, 0};

    sram_window_reader dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .start     (start),
        .startKern (startKern),
        .startRow  (startRow),
        .startCol  (startCol),
        .busy      (busy),
        .err       (err),
        .kernAddr  (kernAddr),
        .pixAddr   (pixAddr),
        .CS        (CS),
        .RD        (RD),
        .WE        (WE),
        .dataIn    (dataIn),
        .winData   (winData),
        .winTap    (winTap),
        .winValid  (winValid),
        .winReady  (winReady),
        .winLast   (winLast)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (CS && RD && !WE) sram_q <= mem[{kernAddr, pixAddr}];
    end
    assign dataIn = sram_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "/busy"},     busy,     0);
        check({tag, "/err"},      err,      0);
        check({tag, "/CS"},       CS,       0);
        check({tag, "/RD"},       RD,       0);
        check({tag, "/WE"},       WE,       0);
        check({tag, "/kernAddr"}, kernAddr, 0);
        check({tag, "/pixAddr"},  pixAddr,  0);
        check({tag, "/winValid"}, winValid, 0);
        check({tag, "/winData"},  winData,  0);
        check({tag, "/winTap"},   winTap,   0);
        check({tag, "/winLast"},  winLast,  0);
    endtask

    // mode 0: winReady held high; mode 1: winReady pattern 1,0,0,1 repeating.
    // restart_tap >= 0 pulses start while that tap is presented.
    task automatic run_window(input string tag, input logic [3:0] kern,
                              input logic [2:0] row, input logic [2:0] col,
                              input int mode, input int ev [9], input int ea [9],
                              input int n_ea, input int restart_tap);
        int         n_pop;
        int         n_rd;
        int         cyc;
        int         first_valid;
        int         last_pop;
        bit         restarted;
        bit         hold;
        logic [7:0] hold_data;
        logic [3:0] hold_tap;
        n_pop = 0; n_rd = 0; cyc = 0; first_valid = -1; last_pop = -1;
        restarted = 0; hold = 0; hold_data = 8'd0; hold_tap = 4'd0;

        @(negedge Clk);
        startKern = kern; startRow = row; startCol = col; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        check({tag, "/busy_rise"}, busy, 1);

        while (n_pop < 9 && cyc < 80) begin
            if (cyc > 0) @(negedge Clk);
            start = 1'b0;
            winReady = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            #1;
            check({tag, "/err_low"}, err, 0);
            check({tag, "/WE_low"},  WE,  0);
            if (RD) begin
                check({tag, "/kernAddr"}, kernAddr, 32'(kern));
                if (n_rd < n_ea) check($sformatf("%s/pixAddr%0d", tag, n_rd), pixAddr, 32'(ea[n_rd]));
                else             check({tag, "/extra_rd"}, 32'(n_rd), 32'(n_ea));
                n_rd++;
            end
            if (hold) begin
                check({tag, "/hold_valid"}, winValid, 1);
                check({tag, "/hold_data"},  winData,  32'(hold_data));
                check({tag, "/hold_tap"},   winTap,   32'(hold_tap));
            end
            hold = 0;
            if (winValid) begin
                if (first_valid < 0) first_valid = cyc;
                if (winReady) begin
                    check($sformatf("%s/tap%0d", tag, n_pop),  winTap,  32'(n_pop));
                    check($sformatf("%s/data%0d", tag, n_pop), winData, 32'(ev[n_pop]));
                    check($sformatf("%s/last%0d", tag, n_pop), winLast, (n_pop == 8) ? 1 : 0);
                    n_pop++;
                    last_pop = cyc;
                end else begin
                    hold = 1; hold_data = winData; hold_tap = winTap;
                end
            end
            check({tag, "/outstanding"}, ((n_rd - n_pop) <= 2) ? 1 : 0, 1);
            if (restart_tap >= 0 && !restarted && winValid && winTap == 4'(restart_tap)) begin
                start = 1'b1; startRow = 3'd0; startCol = 3'd0; startKern = 4'h5;
                restarted = 1;
            end
            cyc++;
        end
        start = 1'b0;
        check({tag, "/all_taps"}, 32'(n_pop), 9);
        check({tag, "/rd_count"}, 32'(n_rd), 32'(n_ea));
        if (mode == 0) begin
            check({tag, "/first_valid_cyc"}, 32'(first_valid), 2);
            check({tag, "/last_pop_cyc"},    32'(last_pop),    10);
        end
        @(negedge Clk);
        #1;
        check({tag, "/busy_fall"},  busy,     0);
        check({tag, "/valid_idle"}, winValid, 0);
    endtask

    initial begin
        int  waited;
        bit  found;

        for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
        Rst_n = 1'b0; start = 1'b0; startKern = 4'd0; startRow = 3'd0; startCol = 3'd0;
        winReady = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        check_reset_outputs("reset");
        Rst_n = 1'b1;

        run_window("full_ready", 4'h0, 3'd2, 3'd3, 0, ev_r2c3, ev_r2c3, 9, -1);
        run_window("toggle_ready", 4'h0, 3'd2, 3'd3, 1, ev_r2c3, ev_r2c3, 9, -1);

`ifdef SRAM_WINDOW_PAD_EN
        run_window("pad", 4'h0, 3'd6, 3'd6, 0, ev_pad, ea_pad, 4, -1);
`else
        @(negedge Clk);
        startKern = 4'h0; startRow = 3'd6; startCol = 3'd6; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        #1;
        check("reject/err_pulse", err,  1);
        check("reject/busy",      busy, 0);
        @(negedge Clk);
        #1;
        check("reject/err_clear", err,  0);
        check("reject/busy_low",  busy, 0);
        check("reject/no_rd",     RD,   0);
`endif

        run_window("restart_ignored", 4'h0, 3'd2, 3'd3, 0, ev_r2c3, ev_r2c3, 9, 4);

        // Reset while tap 5 is presented.
        @(negedge Clk);
        startKern = 4'h0; startRow = 3'd2; startCol = 3'd3; start = 1'b1;
        @(negedge Clk);
        start = 1'b0; winReady = 1'b1;
        found = 0; waited = 0;
        while (!found && waited < 40) begin
            #1;
            if (winValid && winTap == 4'd5) found = 1;
            else begin
                @(negedge Clk);
                waited++;
            end
        end
        check("midreset/reach_tap5", found, 1);
        Rst_n = 1'b0;
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check_reset_outputs("midreset");
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            #1;
            check("midreset/no_rd",    RD,       0);
            check("midreset/no_valid", winValid, 0);
        end

        run_window("after_reset", 4'h0, 3'd2, 3'd3, 0, ev_r2c3, ev_r2c3, 9, -1);
        run_window("kern_A", 4'hA, 3'd2, 3'd3, 1, ev_kA, ev_r2c3, 9, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_window_reader.md
# sram_window_reader

Downstream read sequencer for the `syncRAM` kernel/pixel store. On a start command it fetches one 3x3 window of 8-bit pixels from an 8x8 image slot, selected by `kernAddr`, through the SRAM's synchronous read port. It streams the nine taps in raster order to the convolution MAC over a valid/ready handshake, and absorbs MAC backpressure with a 2-entry output buffer.

## Interface
Parameters:
- `DATA_W`, 8: pixel width.
- `KERN_AW`, 4: kernel/slot address width.
- `PIX_AW`, 6: pixel address width; image is `IMG_W` x `IMG_W`.
- `IMG_W`, 8: image side length.
- `WIN`, 3: window side length; `WIN*WIN` taps per window.

Ports:
- `Clk`  in  1  clock; all logic on the rising edge.
- `Rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request one window fetch; accepted only in IDLE.
- `startKern`  in  KERN_AW  slot to read.
- `startRow`, `startCol`  in  3 each  top-left corner of the window.
- `busy`  out  1  high from the cycle after acceptance until the last tap has been popped.
- `err`  out  1  one-cycle pulse when a start is rejected.
- `kernAddr`  out  KERN_AW  SRAM slot address.
- `pixAddr`  out  PIX_AW  SRAM pixel address.
- `CS`, `RD`  out  1  SRAM chip select and read strobe.
- `WE`  out  1  tied 0.
- `dataIn`  in  DATA_W  SRAM `dataOut`; valid the cycle after `RD`.
- `winData`  out  DATA_W  tap value.
- `winTap`  out  4  tap index, 0..8.
- `winValid`  out  1  tap available.
- `winReady`  in  1  MAC accepts the tap.
- `winLast`  out  1  high with tap 8.

## Operation
- State machine states: IDLE, ISSUE, DRAIN.
- IDLE -> ISSUE on `start`. The request is latched and the tap counter is cleared.
- ISSUE issues one tap per cycle, only while credits allow.
  - Condition: buffer count + in-flight reads < 2.
  - Tap t reads row `startRow + t/3`, column `startCol + t%3`.
  - `pixAddr = row*IMG_W + col`, computed with 4-bit row/column sums.
- After tap 8 is issued, ISSUE -> DRAIN.
- DRAIN -> IDLE when the tap 8 handshake completes (`winValid && winReady && winLast`).
- Issuing a tap means `CS=RD=1` for one cycle. The next cycle, `dataIn` is written into the buffer together with its tap index.
- Handshake: `winValid` and `winData`/`winTap`/`winLast` stay stable until `winReady`. The buffer never overflows, because of the credit rule.
- `start` while busy: ignored, with no `err` pulse.
- Reset values: `busy=0`, `err=0`, `CS=RD=WE=0`, `kernAddr=0`, `pixAddr=0`, `winValid=0`, `winData=0`, `winTap=0`, `winLast=0`. The buffer is emptied and the state is IDLE.
- `Rst_n` low mid-window: all of the above apply on the next edge. The partial window is discarded and no further reads are issued.

## Timing
- Start accepted at edge E0.
- First `RD` is high in cycle E0+1.
- Data is captured at E0+2.
- `winValid` is high at E0+2 at the latest, i.e. combinationally from buffer non-empty after the capture edge.
- With `winReady` held at 1: one tap per cycle, taps 0..8 on consecutive cycles, and `busy` falls the cycle after tap 8 is popped.
- With `winReady=0`: at most 2 taps are buffered, and `RD` stays low until a pop frees a credit. A pop and an issue in the same cycle are allowed.

## Configuration
- `SRAM_WINDOW_PAD_EN` defined:
  - A tap whose row or column is >= `IMG_W` issues no SRAM read (`CS=RD=0` that cycle).
  - Its slot still consumes a credit and delivers `winData=0` in tap order.
- Not defined:
  - A `start` with `startRow > IMG_W-WIN` or `startCol > IMG_W-WIN` is rejected: `err` pulses for one cycle and the block stays in IDLE.
  - Every issued tap is a real read.

## Structure
- Shared package `cnn_mem_pkg`:
  - `IMG_W`, `WIN`, `DATA_W`, `KERN_AW`, `PIX_AW`.
  - The state enum {IDLE, ISSUE, DRAIN}.
  - A tap-entry type {data, tap, last, pad}.
- One sub-module: `win_skid_fifo`, a 2-entry FIFO of tap entries with push/pop, count and empty/full. The sequencer, credit logic and address generation stay in the top module.

## Test plan
- Preload the slot with pix[i]=i. Request row 2, col 3, `winReady=1` -> taps 19,20,21,27,28,29,35,36,37 on 9 consecutive cycles, tap 8 with `winLast`, `winValid` first at E0+2.
- Same request, `winReady` toggling 1,0,0,1… -> identical value/tap sequence, at most 2 outstanding, no `RD` while out of credit.
- Request row 6, col 6:
  - With `SRAM_WINDOW_PAD_EN`: taps 54,55,0,62,63,0,0,0,0, and no `RD` on the padded taps.
  - Without it: a single `err` pulse, `busy` stays 0.
- Pulse `start` again during tap 4 -> ignored, the window completes unchanged, `err=0`.
- Drop `Rst_n` during tap 5 for one edge -> all outputs at reset values the next cycle. A new start then returns a correct full window.
- `startKern=4'hA` -> `kernAddr=4'hA` on every `RD` cycle, `WE=0` throughout.
